// File: rtl/scoreboard_register_file_pkg.sv
// Shared constants and address type for the scoreboarded register file.
package scoreboard_register_file_pkg;
  localparam int DEF_D = 5;
  localparam int DEF_W = 32;
  localparam int DEF_R = 2;

  typedef logic [DEF_D-1:0] reg_addr_t;
endpackage

// File: rtl/scoreboard_register_file_if.sv
// Read/write/reserve bus of the scoreboarded register file.
interface scoreboard_register_file_if
  import scoreboard_register_file_pkg::*;
#(
  parameter int D = DEF_D,
  parameter int W = DEF_W,
  parameter int R = DEF_R
);
  logic [R-1:0][D-1:0] rd_addr;
  logic [R-1:0][W-1:0] rd_data;
  logic [R-1:0]        rd_busy;
  logic                wr_en;
  logic [D-1:0]        wr_addr;
  logic [W-1:0]        wr_data;
  logic                rsv_en;
  logic [D-1:0]        rsv_addr;
  logic [D:0]          busy_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, busy_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, busy_count
  );
endinterface

// File: rtl/scoreboard_register_file_read_port.sv
// One combinational read port: register mux, same-cycle write bypass, busy lookup.
module rf_read_port
  import scoreboard_register_file_pkg::*;
#(
  parameter int D        = DEF_D,
  parameter int W        = DEF_W,
  parameter int ZERO_REG = 1
) (
  input  logic                       rst_n,
  input  logic [D-1:0]               addr,
  input  logic [(1<<D)-1:0][W-1:0]   regs_q,
  input  logic [(1<<D)-1:0]          busy_q,
  input  logic                       wr_en,
  input  logic [D-1:0]               wr_addr,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               data,
  output logic                       busy
);
  logic is_zero;
  logic hit;

  always_comb begin
    is_zero = (ZERO_REG != 0) && (addr == '0);
    hit     = wr_en && (wr_addr == addr);
    data    = regs_q[addr];
    busy    = busy_q[addr];
    // Reset forces quiet outputs even while a bypassing write is presented.
    if (!rst_n || is_zero) begin
      data = '0;
      busy = 1'b0;
    end else if (hit) begin
      data = wr_data;
      busy = 1'b0;
    end
  end
endmodule

// File: rtl/scoreboard_register_file.sv
// Register file with per-register busy bits set at issue (reserve) and cleared at writeback.
module scoreboard_register_file
  import scoreboard_register_file_pkg::*;
#(
  parameter int D        = DEF_D,
  parameter int W        = DEF_W,
  parameter int R        = DEF_R,
  parameter int ZERO_REG = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  scoreboard_register_file_if.slave bus
);
  localparam int N = 1 << D;

  logic [N-1:0][W-1:0] regs_q;
  logic [N-1:0]        busy_q;
  logic [D:0]          count_q;
  logic                wr_ok, rsv_ok, inc, dec;
  logic [R-1:0][W-1:0] rd_data;
  logic [R-1:0]        rd_busy;

  always_comb begin
    wr_ok  = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == '0));
    rsv_ok = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));
    // A reserve landing on the register being written keeps it busy, so no decrement.
    inc    = rsv_ok && !busy_q[bus.rsv_addr];
    dec    = wr_ok && busy_q[bus.wr_addr] && !(rsv_ok && (bus.rsv_addr == bus.wr_addr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else if (wr_ok) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      if (wr_ok)  busy_q[bus.wr_addr]  <= 1'b0;
      if (rsv_ok) busy_q[bus.rsv_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && !dec) begin
      count_q <= count_q + 1'b1;
    end else if (dec && !inc) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign bus.busy_count = count_q;

  for (genvar p = 0; p < R; p++) begin : g_port
    rf_read_port #(.D(D), .W(W), .ZERO_REG(ZERO_REG)) u_port (
      .rst_n   (rst_n),
      .addr    (bus.rd_addr[p]),
      .regs_q  (regs_q),
      .busy_q  (busy_q),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .data    (rd_data[p]),
      .busy    (rd_busy[p])
    );
  end

  assign bus.rd_data = rd_data;
  assign bus.rd_busy = rd_busy;
endmodule

// File: tb/tb_scoreboard_register_file.sv
// Scoreboard bench: behavioural reference model, expected reads/counts queued then compared.
module tb_scoreboard_register_file;
  import scoreboard_register_file_pkg::*;

  localparam int D = 5;
  localparam int W = 32;
  localparam int R = 4;
  localparam int N = 1 << D;

  typedef struct {
    logic [W-1:0] data;
    logic         busy;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [W-1:0] m_regs [N];
  logic         m_busy [N];
  rd_exp_t      rd_q [$];
  logic [D:0]   cnt_q [$];

  scoreboard_register_file_if #(.D(D), .W(W), .R(R)) bus ();

  scoreboard_register_file #(.D(D), .W(W), .R(R), .ZERO_REG(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [D:0] m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c[D:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // One clock: drive at negedge, check combinational reads, then registered count after the edge.
  task automatic cycle(input string tag, input logic we, input int wa, input logic [W-1:0] wd,
                       input logic re, input int ra,
                       input int a0, input int a1, input int a2, input int a3);
    int      addrs [4];
    rd_exp_t e, got;
    logic [D:0] ce;
    addrs = '{a0, a1, a2, a3};
    @(negedge clk);
    bus.wr_en    = we;
    bus.wr_addr  = wa[D-1:0];
    bus.wr_data  = wd;
    bus.rsv_en   = re;
    bus.rsv_addr = ra[D-1:0];
    for (int p = 0; p < R; p++) begin
      bus.rd_addr[p] = addrs[p][D-1:0];
      if (addrs[p] == 0) begin
        e.data = '0; e.busy = 1'b0;
      end else if (we && wa == addrs[p]) begin
        e.data = wd; e.busy = 1'b0;
      end else begin
        e.data = m_regs[addrs[p]]; e.busy = m_busy[addrs[p]];
      end
      rd_q.push_back(e);
    end
    #1;
    for (int p = 0; p < R; p++) begin
      e = rd_q.pop_front();
      got.data = bus.rd_data[p];
      got.busy = bus.rd_busy[p];
      checks++;
      if (got.data !== e.data) begin
        errors++;
        $display("FAIL %s rd_data port%0d addr%0d: got %h expected %h", tag, p, addrs[p], got.data, e.data);
      end
      checks++;
      if (got.busy !== e.busy) begin
        errors++;
        $display("FAIL %s rd_busy port%0d addr%0d: got %b expected %b", tag, p, addrs[p], got.busy, e.busy);
      end
    end
    @(posedge clk);
    if (we && wa != 0) begin
      m_regs[wa] = wd;
      m_busy[wa] = 1'b0;
    end
    if (re && ra != 0) m_busy[ra] = 1'b1;
    cnt_q.push_back(m_count());
    #1;
    ce = cnt_q.pop_front();
    checks++;
    if (bus.busy_count !== ce) begin
      errors++;
      $display("FAIL %s busy_count: got %0d expected %0d", tag, bus.busy_count, ce);
    end
  endtask

  task automatic idle(input string tag, input int a0, input int a1, input int a2, input int a3);
    cycle(tag, 1'b0, 0, '0, 1'b0, 0, a0, a1, a2, a3);
  endtask

  task automatic test_reset();
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hCAFE_F00D;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
    for (int p = 0; p < R; p++) bus.rd_addr[p] = 5'd3;
    model_reset();
    repeat (2) @(negedge clk);
    for (int p = 0; p < R; p++) begin
      checks++;
      if (bus.rd_data[p] !== '0 || bus.rd_busy[p] !== 1'b0) begin
        errors++;
        $display("FAIL reset_bypass port%0d: got %h/%b expected 0/0", p, bus.rd_data[p], bus.rd_busy[p]);
      end
    end
    checks++;
    if (bus.busy_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", bus.busy_count);
    end
    bus.wr_en = 1'b0; bus.rsv_en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < N / R; i++) idle("reset_scan", 4*i, 4*i+1, 4*i+2, 4*i+3);
  endtask

  task automatic test_reserve_write();
    cycle("rsv_r5", 1'b0, 0, '0, 1'b1, 5, 5, 5, 0, 1);
    idle("r5_busy", 5, 5, 6, 4);
    cycle("wr_r5", 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 5, 5, 4, 6);
    idle("r5_done", 5, 5, 5, 5);
  endtask

  task automatic test_same_cycle();
    cycle("rsvwr_r7", 1'b1, 7, 32'h1234_5678, 1'b1, 7, 7, 6, 8, 0);
    idle("r7_after", 7, 7, 0, 1);
    cycle("rsv_busy_r7", 1'b0, 0, '0, 1'b1, 7, 7, 7, 7, 7);
    cycle("wr_r7", 1'b1, 7, 32'h0BAD_F00D, 1'b0, 0, 7, 1, 2, 7);
    cycle("wr_nonbusy_r8", 1'b1, 8, 32'h0000_0088, 1'b0, 0, 8, 7, 8, 9);
    idle("r8_after", 8, 8, 7, 9);
  endtask

  task automatic test_zero_reg();
    cycle("zero_rsvwr", 1'b1, 0, 32'hFFFF_FFFF, 1'b1, 0, 0, 0, 0, 0);
    idle("zero_after", 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    cycle("mid_rsv_r1", 1'b0, 0, '0, 1'b1, 1, 1, 2, 3, 7);
    cycle("mid_rsv_r2", 1'b0, 0, '0, 1'b1, 2, 1, 2, 3, 7);
    cycle("mid_rsv_r3", 1'b0, 0, '0, 1'b1, 3, 1, 2, 3, 7);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd1; bus.wr_data = 32'h5555_AAAA;
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
    bus.rd_addr[0] = 5'd1; bus.rd_addr[1] = 5'd2; bus.rd_addr[2] = 5'd7; bus.rd_addr[3] = 5'd8;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int p = 0; p < R; p++) begin
      checks++;
      if (bus.rd_data[p] !== '0 || bus.rd_busy[p] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset port%0d: got %h/%b expected 0/0", p, bus.rd_data[p], bus.rd_busy[p]);
      end
    end
    checks++;
    if (bus.busy_count !== '0) begin
      errors++;
      $display("FAIL mid_reset_count: got %0d expected 0", bus.busy_count);
    end
    #1;
    bus.wr_en = 1'b0; bus.rsv_en = 1'b0;
    rst_n = 1'b1;
    idle("post_reset", 1, 2, 7, 8);
    cycle("post_reset_rsv", 1'b0, 0, '0, 1'b1, 4, 4, 1, 2, 3);
    idle("post_reset_chk", 4, 1, 2, 3);
  endtask

  task automatic test_multi_port();
    cycle("r9_bypass", 1'b1, 9, 32'hA5A5_A5A5, 1'b0, 0, 9, 9, 9, 9);
    idle("r9_after", 9, 9, 9, 9);
  endtask

  task automatic test_back_to_back();
    int a [4];
    int wa, ra;
    logic we, re;
    for (int n = 0; n < 300; n++) begin
      we = ($urandom_range(0, 2) != 0);
      re = ($urandom_range(0, 1) != 0);
      wa = $urandom_range(0, 15);
      ra = (n % 7 == 0) ? wa : $urandom_range(0, 15);
      for (int p = 0; p < 4; p++) a[p] = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
      cycle("random", we, wa, $urandom, re, ra, a[0], a[1], a[2], a[3]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rsv_en = 1'b0; bus.rsv_addr = '0; bus.rd_addr = '0;
    test_reset();
    test_reserve_write();
    test_same_cycle();
    test_zero_reg();
    test_reset_mid();
    test_multi_port();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
